// File: rtl/dpmu_pkg.sv
// Shared constants, reset codes and sequencer state encoding for the DVFS path.
// NDOM/VW/FW fix the bus layout; the *_DEF values are default wait lengths.
package dpmu_pkg;

  localparam int NDOM = 3;
  localparam int VW   = 2;
  localparam int FW   = 3;

  localparam logic [VW-1:0] V_RST = 2'd1;
  localparam logic [FW-1:0] F_RST = 3'd2;

  localparam int SETTLE_CYC_DEF = 16;
  localparam int LOCK_CYC_DEF   = 8;
  localparam int TMO_CYC_DEF    = 255;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_V_REQ,
    ST_V_SETTLE,
    ST_F_SET,
    ST_F_LOCK,
    ST_DONE
  } dvfs_state_t;

endpackage

// File: rtl/dvfs_wait_timer.sv
// Loadable down-counter with a zero flag; counts down to zero and holds there.
// A load value of N-1 makes zero assert on the N-th cycle after the load edge.
module dvfs_wait_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/dvfs_sequencer.sv
// Applies V/F target sets domain by domain, raising V before F and lowering F before V.
// One regulator request in flight at a time; new targets accepted only while idle.
module dvfs_sequencer
  import dpmu_pkg::*;
#(
  parameter int SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int LOCK_CYC   = LOCK_CYC_DEF,
  parameter int TMO_CYC    = TMO_CYC_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tgt_valid,
  output logic                 tgt_ready,
  input  logic [NDOM*VW-1:0]   tgt_v,
  input  logic [NDOM*FW-1:0]   tgt_f,
  output logic                 vreg_req,
  output logic [1:0]           vreg_dom,
  output logic [VW-1:0]        vreg_code,
  input  logic                 vreg_ack,
  output logic [NDOM*VW-1:0]   cur_v,
  output logic [NDOM*FW-1:0]   cur_f,
  output logic                 busy,
  output logic                 err
);

  localparam int CYC_MAX = (TMO_CYC > SETTLE_CYC) ?
                           ((TMO_CYC > LOCK_CYC) ? TMO_CYC : LOCK_CYC) :
                           ((SETTLE_CYC > LOCK_CYC) ? SETTLE_CYC : LOCK_CYC);
  localparam int CW = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] LOCK_LD   = CW'(LOCK_CYC - 1);
  localparam logic [CW-1:0] TMO_LD    = CW'(TMO_CYC - 1);
  localparam logic [1:0]    LAST_DOM  = 2'(NDOM - 1);

  dvfs_state_t state, state_nxt;

  logic [1:0]         d;
  logic [NDOM*VW-1:0] tv_q;
  logic [NDOM*FW-1:0] tf_q;
  logic [VW-1:0]      code_q;
  logic [VW-1:0]      tv_d, cv_d;
  logic [FW-1:0]      tf_d, cf_d;
  logic               tmr_load, tmr_zero;
  logic [CW-1:0]      tmr_val;

  assign tv_d = tv_q[int'(d)*VW +: VW];
  assign cv_d = cur_v[int'(d)*VW +: VW];
  assign tf_d = tf_q[int'(d)*FW +: FW];
  assign cf_d = cur_f[int'(d)*FW +: FW];

  // One timer serves the ack timeout, the regulator settle and the PLL lock waits.
  dvfs_wait_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    case (state)
      ST_IDLE: if (tgt_valid) state_nxt = ST_SCAN;
      ST_SCAN: begin
        if (tv_d > cv_d || (tf_d == cf_d && tv_d < cv_d)) begin
          state_nxt = ST_V_REQ;
          tmr_load  = 1'b1;
          tmr_val   = TMO_LD;
        end else if (tf_d != cf_d) begin
          state_nxt = ST_F_SET;
        end else if (d == LAST_DOM) begin
          state_nxt = ST_DONE;
        end
      end
      ST_V_REQ: begin
        if (vreg_ack) begin
          state_nxt = ST_V_SETTLE;
          tmr_load  = 1'b1;
          tmr_val   = SETTLE_LD;
        end else if (tmr_zero) begin
          state_nxt = ST_DONE;
        end
      end
      ST_V_SETTLE: if (tmr_zero) state_nxt = ST_SCAN;
      ST_F_SET: begin
        state_nxt = ST_F_LOCK;
        tmr_load  = 1'b1;
        tmr_val   = LOCK_LD;
      end
      ST_F_LOCK: if (tmr_zero) state_nxt = ST_SCAN;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d      <= '0;
      tv_q   <= '0;
      tf_q   <= '0;
      code_q <= '0;
      cur_v  <= {NDOM{V_RST}};
      cur_f  <= {NDOM{F_RST}};
      err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (tgt_valid) begin
            tv_q <= tgt_v;
            tf_q <= tgt_f;
            err  <= 1'b0;
            d    <= '0;
          end
        end
        ST_SCAN: begin
          if (tv_d > cv_d) begin
            code_q <= cv_d + 1'b1;
          end else if (tf_d == cf_d) begin
            if (tv_d < cv_d) begin
              code_q <= cv_d - 1'b1;
            end else if (d != LAST_DOM) begin
              d <= d + 1'b1;
            end
          end
        end
        ST_V_REQ: begin
          if (vreg_ack) begin
            cur_v[int'(d)*VW +: VW] <= code_q;
          end else if (tmr_zero) begin
            err <= 1'b1;
          end
        end
        ST_F_SET: cur_f[int'(d)*FW +: FW] <= tf_d;
        default: ;
      endcase
    end
  end

  // Request is decoded from state so an async reset drops it without a clock edge.
  always_comb begin
    tgt_ready = (state == ST_IDLE);
    busy      = (state != ST_IDLE);
    vreg_req  = (state == ST_V_REQ);
    vreg_dom  = vreg_req ? d : 2'd0;
    vreg_code = vreg_req ? code_q : '0;
  end

endmodule

// File: tb/tb_dvfs_sequencer.sv
// Scoreboard bench: a reference model queues expected regulator/V/F events per target set,
// a negedge monitor pops and compares them, and busy spans are checked against the model.
module tb_dvfs_sequencer;
  import dpmu_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 tgt_valid = 1'b0;
  logic                 tgt_ready;
  logic [NDOM*VW-1:0]   tgt_v = '0;
  logic [NDOM*FW-1:0]   tgt_f = '0;
  logic                 vreg_req;
  logic [1:0]           vreg_dom;
  logic [VW-1:0]        vreg_code;
  logic                 vreg_ack;
  logic [NDOM*VW-1:0]   cur_v;
  logic [NDOM*FW-1:0]   cur_f;
  logic                 busy;
  logic                 err;

  dvfs_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .tgt_valid (tgt_valid),
    .tgt_ready (tgt_ready),
    .tgt_v     (tgt_v),
    .tgt_f     (tgt_f),
    .vreg_req  (vreg_req),
    .vreg_dom  (vreg_dom),
    .vreg_code (vreg_code),
    .vreg_ack  (vreg_ack),
    .cur_v     (cur_v),
    .cur_f     (cur_f),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] kind;
    logic [1:0] dom;
    logic [3:0] val;
  } ev_t;

  localparam logic [1:0] K_REQ = 2'd1;
  localparam logic [1:0] K_V   = 2'd2;
  localparam logic [1:0] K_F   = 2'd3;

  ev_t exp_q[$];
  int  total = 0;
  int  bad   = 0;
  int  mcv[NDOM];
  int  mcf[NDOM];
  logic mon_en = 1'b0;
  logic ack_en = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic note(input ev_t ev);
    ev_t e;
    if (exp_q.size() == 0) begin
      chk("unexpected_event", 32'(ev), 32'h0);
    end else begin
      e = exp_q.pop_front();
      chk("event", 32'(ev), 32'(e));
    end
  endtask

  logic               prev_req = 1'b0;
  logic [NDOM*VW-1:0] prev_v = '0;
  logic [NDOM*FW-1:0] prev_f = '0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (vreg_req && !prev_req) note({K_REQ, vreg_dom, 2'b00, vreg_code});
      for (int i = 0; i < NDOM; i++) begin
        if (cur_v[i*VW +: VW] != prev_v[i*VW +: VW])
          note({K_V, 2'(i), 2'b00, cur_v[i*VW +: VW]});
        if (cur_f[i*FW +: FW] != prev_f[i*FW +: FW])
          note({K_F, 2'(i), 1'b0, cur_f[i*FW +: FW]});
      end
    end
    prev_req <= vreg_req;
    prev_v   <= cur_v;
    prev_f   <= cur_f;
  end

  // Regulator acks in the third cycle of each request while ack_en is set.
  initial begin
    int age;
    age = 0;
    vreg_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (vreg_req) age++;
      else age = 0;
      vreg_ack = ack_en && vreg_req && (age == 3);
    end
  end

  task automatic model_reset();
    for (int i = 0; i < NDOM; i++) begin
      mcv[i] = int'(V_RST);
      mcf[i] = int'(F_RST);
    end
  endtask

  task automatic push_ev(input logic [1:0] k, input int dom, input int val);
    ev_t e;
    e.kind = k;
    e.dom  = 2'(dom);
    e.val  = 4'(val);
    exp_q.push_back(e);
  endtask

  task automatic model(input logic [NDOM*VW-1:0] tv, input logic [NDOM*FW-1:0] tf,
                       input bit acks, output int busy_exp);
    int  v, f, code;
    bit  stop, dom_done;
    busy_exp = 0;
    stop = 0;
    for (int i = 0; i < NDOM; i++) begin
      if (!stop) begin
        v = int'(tv[i*VW +: VW]);
        f = int'(tf[i*FW +: FW]);
        dom_done = 0;
        for (int s = 0; s < 16; s++) begin
          if (!dom_done && !stop) begin
            busy_exp++;
            if (v > mcv[i] || (v < mcv[i] && f == mcf[i])) begin
              code = (v > mcv[i]) ? mcv[i] + 1 : mcv[i] - 1;
              push_ev(K_REQ, i, code);
              if (!acks) begin
                busy_exp += TMO_CYC_DEF;
                stop = 1;
              end else begin
                push_ev(K_V, i, code);
                mcv[i] = code;
                busy_exp += 3 + SETTLE_CYC_DEF;
              end
            end else if (f != mcf[i]) begin
              push_ev(K_F, i, f);
              mcf[i] = f;
              busy_exp += 1 + LOCK_CYC_DEF;
            end else begin
              dom_done = 1;
            end
          end
        end
      end
    end
    busy_exp++;
  endtask

  task automatic send(input logic [NDOM*VW-1:0] v, input logic [NDOM*FW-1:0] f,
                      input bit acks, output int busy_exp);
    int n;
    n = 0;
    while (!tgt_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    ack_en    = acks;
    tgt_v     = v;
    tgt_f     = f;
    tgt_valid = 1'b1;
    model(v, f, acks, busy_exp);
    @(negedge clk);
    tgt_valid = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 3000) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int exp_busy, n;
    model_reset();
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_cur_v", 32'(cur_v), 32'h15);
    chk("rst_cur_f", 32'(cur_f), 32'h092);
    chk("rst_ready", 32'(tgt_ready), 32'h1);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_req", 32'(vreg_req), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_dom_code", 32'({vreg_dom, vreg_code}), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;

    // core1 falls: F first, lock, then a single V step to 00
    send(6'b01_01_00, 9'b010_010_000, 1'b1, exp_busy);
    wait_idle(n);
    chk("fall_busy", 32'(n), 32'(exp_busy));
    chk("fall_sb_empty", 32'(exp_q.size()), 32'h0);
    chk("fall_cur_v", 32'(cur_v), 32'h14);

    // unchanged target: three scans plus done
    send(6'b01_01_00, 9'b010_010_000, 1'b1, exp_busy);
    wait_idle(n);
    chk("same_busy", 32'(n), 32'd4);
    chk("same_sb_empty", 32'(exp_q.size()), 32'h0);

    // core2 raise with no ack: timeout
    send(6'b01_10_00, 9'b010_010_000, 1'b0, exp_busy);
    wait_idle(n);
    chk("tmo_busy", 32'(n), 32'(exp_busy));
    chk("tmo_err", 32'(err), 32'h1);
    chk("tmo_req", 32'(vreg_req), 32'h0);
    chk("tmo_cur_v", 32'(cur_v), 32'h14);
    chk("tmo_mem_f", 32'(cur_f[8:6]), 32'h2);
    chk("tmo_sb_empty", 32'(exp_q.size()), 32'h0);

    // all domains raised to max; next target offered early and held
    send(6'b11_11_11, 9'b111_111_111, 1'b1, exp_busy);
    chk("raise_err_clr", 32'(err), 32'h0);
    n = 0;
    while (busy && n < 3000) begin
      n++;
      if (n == 60) begin
        tgt_v     = 6'b01_01_01;
        tgt_f     = 9'b010_010_010;
        tgt_valid = 1'b1;
      end
      @(negedge clk);
    end
    chk("raise_busy", 32'(n), 32'(exp_busy));
    chk("raise_sb_empty", 32'(exp_q.size()), 32'h0);
    chk("raise_cur", 32'({cur_v, cur_f}), 32'h7FFF);
    model(6'b01_01_01, 9'b010_010_010, 1'b1, exp_busy);
    @(negedge clk);
    tgt_valid = 1'b0;
    chk("held_accepted", 32'(busy), 32'h1);

    // reset while settling after the first falling V step
    n = 0;
    while (!vreg_req && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("abort_req_seen", 32'(vreg_req), 32'h1);
    n = 0;
    while (vreg_req && n < 500) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    chk("abort_pre_v0", 32'(cur_v[1:0]), 32'h2);
    chk("abort_pre_busy", 32'(busy), 32'h1);
    #2;
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("abort_req", 32'(vreg_req), 32'h0);
    chk("abort_cur_v", 32'(cur_v), 32'h15);
    chk("abort_cur_f", 32'(cur_f), 32'h092);
    chk("abort_ready", 32'(tgt_ready), 32'h1);
    exp_q.delete();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;

    send(6'b01_01_01, 9'b010_010_010, 1'b1, exp_busy);
    wait_idle(n);
    chk("post_rst_busy", 32'(n), 32'd4);
    chk("post_rst_sb_empty", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
